// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO family.
//   fifo_mode_e  : read-side behaviour, registered output or first-word-fall-through
//   fifo_ptr_w() : pointer width for a given depth
//   fifo_cnt_w() : occupancy counter width for a given depth (must reach DEPTH)
//   fifo_mode()  : maps the integer FWFT parameter onto fifo_mode_e
// ---------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic {
      FIFO_REG  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Pointers index DEPTH entries and wrap naturally because DEPTH is a power of two.
   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so the counter can represent a completely full FIFO.
   function automatic int fifo_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic fifo_mode_e fifo_mode(input int fwft);
      return (fwft != 0) ? FIFO_FWFT : FIFO_REG;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// DATA_WIDTH x DEPTH register array used as FIFO storage.
//   clock    : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (asynchronous read)
//   rdata_o  : read data, combinational from raddr_i
// Contents are deliberately not reset; the control logic tracks validity.
// ---------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = fifo_ptr_w(DEPTH)
) (
   input  logic                  clock,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Single synchronous write port; no reset so the array maps onto plain flops or RAM.
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
// Parametrised single-clock FIFO with occupancy count, almost flags, read-valid
// and overflow/underflow pulses. FWFT selects registered-read or fall-through.
//   clock        : single clock, rising edge
//   rst          : asynchronous active-low reset
//   wr_en / din  : write request and data
//   rd_en        : read request (pop)
//   dout         : read data
//   dout_valid   : newly popped word (registered) or !empty (FWFT)
//   full / empty / almost_full / almost_empty / count : registered status
//   overflow / underflow : one-cycle pulses for rejected write / read
// ---------------------------------------------------------------------------
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int         PTR_W = fifo_ptr_w(DEPTH);
   localparam int         CNT_W = fifo_cnt_w(DEPTH);
   localparam fifo_mode_e MODE  = fifo_mode(FWFT);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  af_q, af_d;
   logic                  ae_q, ae_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_mem (
      .clock   (clock),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (din),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   // A read frees a slot in the same edge, so a write at full is still accepted
   // when paired with a read. A read at empty is never bypassed from the write.
   assign rd_acc = rd_en & ~empty_q;
   assign wr_acc = wr_en & (~full_q | rd_acc);

   // Next-state for pointers, occupancy and flags. Flags are computed from the
   // next count so they change on the same edge as the pointers.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (wr_acc && !rd_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - CNT_W'(1);
      end

      // Only registered mode captures the popped word; FWFT reads the array directly.
      if (MODE == FIFO_REG && rd_acc) begin
         dout_d       = rd_data;
         dout_valid_d = 1'b1;
      end

      full_d      = (count_d == FULL_CNT);
      empty_d     = (count_d == '0);
      af_d        = (count_d >= AF_CNT);
      ae_d        = (count_d <= AE_CNT);
      overflow_d  = wr_en & ~wr_acc;
      underflow_d = rd_en & ~rd_acc;
   end

   // All control state; reset is asynchronous so stored data is discarded at once.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         af_q         <= 1'b0;
         ae_q         <= 1'b1;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         af_q         <= af_d;
         ae_q         <= ae_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   // In FWFT mode the head entry is shown combinationally; when empty it is stale.
   assign dout         = (MODE == FIFO_FWFT) ? rd_data  : dout_q;
   assign dout_valid   = (MODE == FIFO_FWFT) ? ~empty_q : dout_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_sync_fifo
// Bench for param_sync_fifo: one registered-mode instance driven through a
// scoreboard model, and one FWFT instance exercised with directed steps.
// ---------------------------------------------------------------------------
module tb_param_sync_fifo;

   logic        clock;
   logic        rst;

   logic        wr0, rd0;
   logic [15:0] din0, dout0;
   logic        dv0, full0, empty0, af0, ae0, ovf0, unf0;
   logic [4:0]  count0;

   logic        wr1, rd1;
   logic [15:0] din1, dout1;
   logic        dv1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [4:0]  count1;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sbQ[$];
   logic [15:0] mDout;

   param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(0)) dutReg (
      .clock(clock), .rst(rst), .wr_en(wr0), .din(din0), .rd_en(rd0),
      .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(count0),
      .overflow(ovf0), .underflow(unf0)
   );

   param_sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .FWFT(1)) dutFwft (
      .clock(clock), .rst(rst), .wr_en(wr1), .din(din1), .rd_en(rd1),
      .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(count1),
      .overflow(ovf1), .underflow(unf1)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the registered instance, advance the scoreboard with the
   // accept rules, then compare every status output just after the edge.
   task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] data);
      logic rdAcc, wrAcc;
      int   cnt;
      wr0   = wr;
      rd0   = rd;
      din0  = data;
      rdAcc = rd && (sbQ.size() != 0);
      wrAcc = wr && ((sbQ.size() != 16) || rdAcc);
      @(posedge clock);
      if (rdAcc) mDout = sbQ.pop_front();
      if (wrAcc) sbQ.push_back(data);
      cnt = sbQ.size();
      #1;
      checkOutput("count",        32'(count0), 32'(cnt));
      checkOutput("full",         32'(full0),  32'(cnt == 16));
      checkOutput("empty",        32'(empty0), 32'(cnt == 0));
      checkOutput("almost_full",  32'(af0),    32'(cnt >= 14));
      checkOutput("almost_empty", 32'(ae0),    32'(cnt <= 2));
      checkOutput("overflow",     32'(ovf0),   32'(wr && !wrAcc));
      checkOutput("underflow",    32'(unf0),   32'(rd && !rdAcc));
      checkOutput("dout_valid",   32'(dv0),    32'(rdAcc));
      checkOutput("dout",         32'(dout0),  32'(mDout));
   endtask

   initial begin
      rst  = 1'b0;
      wr0  = 1'b0; rd0 = 1'b0; din0 = '0;
      wr1  = 1'b0; rd1 = 1'b0; din1 = '0;
      mDout = '0;
      repeat (2) @(posedge clock);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_count",  32'(count0), 32'd0);
      checkOutput("rst_empty",  32'(empty0), 32'd1);
      checkOutput("rst_ae",     32'(ae0),    32'd1);
      checkOutput("rst_full",   32'(full0),  32'd0);
      checkOutput("rst_af",     32'(af0),    32'd0);
      checkOutput("rst_dout",   32'(dout0),  32'd0);
      checkOutput("rst_dv",     32'(dv0),    32'd0);
      checkOutput("rst_ovf",    32'(ovf0),   32'd0);
      checkOutput("rst_unf",    32'(unf0),   32'd0);
      checkOutput("rst_f_dv",   32'(dv1),    32'd0);
      checkOutput("rst_f_empty", 32'(empty1), 32'd1);
      rst = 1'b1;

      $display("[TB] fill to full, then overflow");
      for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, 16'(i));
      applyStimulus(1'b1, 1'b0, 16'h0011);

      $display("[TB] drain in order, then underflow");
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 16'h0);
      applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("hold_after_underflow", 32'(dout0), 32'h0010);

      $display("[TB] streaming at count 8 across pointer wrap");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0100 + 16'(i));
      for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 16'h0200 + 16'(i));

      $display("[TB] simultaneous write and read at full");
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0300 + 16'(i));
      applyStimulus(1'b1, 1'b1, 16'h03FF);

      $display("[TB] asynchronous reset at count 5");
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("pre_reset_count", 32'(count0), 32'd5);
      wr0 = 1'b0; rd0 = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_count", 32'(count0), 32'd0);
      checkOutput("async_empty", 32'(empty0), 32'd1);
      checkOutput("async_ae",    32'(ae0),    32'd1);
      checkOutput("async_full",  32'(full0),  32'd0);
      checkOutput("async_dout",  32'(dout0),  32'd0);
      checkOutput("async_dv",    32'(dv0),    32'd0);
      sbQ.delete();
      mDout = '0;
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'hA5A5);
      applyStimulus(1'b1, 1'b0, 16'h5A5A);
      applyStimulus(1'b0, 1'b1, 16'h0);
      checkOutput("first_after_reset", 32'(dout0), 32'hA5A5);
      applyStimulus(1'b0, 1'b1, 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0);

      $display("[TB] FWFT single word");
      wr1 = 1'b1; din1 = 16'hBEEF;
      @(posedge clock); #1;
      wr1 = 1'b0;
      checkOutput("fwft_dout",  32'(dout1),  32'hBEEF);
      checkOutput("fwft_dv",    32'(dv1),    32'd1);
      checkOutput("fwft_empty", 32'(empty1), 32'd0);
      checkOutput("fwft_count", 32'(count1), 32'd1);
      @(posedge clock); #1;
      checkOutput("fwft_hold_dout", 32'(dout1), 32'hBEEF);
      checkOutput("fwft_hold_dv",   32'(dv1),   32'd1);
      rd1 = 1'b1;
      @(posedge clock); #1;
      rd1 = 1'b0;
      checkOutput("fwft_pop_empty", 32'(empty1), 32'd1);
      checkOutput("fwft_pop_dv",    32'(dv1),    32'd0);
      checkOutput("fwft_pop_count", 32'(count1), 32'd0);
      checkOutput("fwft_pop_unf",   32'(unf1),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
